// File: rtl/key_pulse_conditioner.sv
// Push-button conditioner: synchronizes an active-low key, debounces press and
// release, and emits a one-cycle pulse per accepted press plus a held level.
module key_pulse_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int CW       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse,
    output logic held
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_HELD         = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    logic          sync1_r;
    logic          sync2_r;
    logic          ks_s;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          pulse_r;
    logic          pulse_nxt_s;
    logic          held_r;
    logic          held_nxt_s;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    assign ks_s = ~sync2_r;

    // Next-state, counter and output decode for the debounce FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pulse_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ks_s) begin
                    state_nxt_s = ST_PRESS_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!ks_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = '0;
                    pulse_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!ks_s) begin
                    state_nxt_s = ST_RELEASE_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (ks_s) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
        held_nxt_s = (state_nxt_s == ST_HELD) || (state_nxt_s == ST_RELEASE_WAIT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            pulse_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pulse_r <= pulse_nxt_s;
            held_r  <= held_nxt_s;
        end
    end

    assign pulse = pulse_r;
    assign held  = held_r;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Bench for key_pulse_conditioner (DEBOUNCE=4): press/release vectors scored
// against latencies, pulse counts and held transitions derived from the spec.
module tb_key_pulse_conditioner;

    logic clk;
    logic reset;
    logic key_n;
    logic pulse;
    logic held;

    key_pulse_conditioner #(.DEBOUNCE(4), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .pulse (pulse),
        .held  (held)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int low_cyc;
        int high_cyc;
        int pulses;
        int rise_j;
        int fall_j;
        bit held_seen;
    } vec_t;

    typedef struct {
        string name;
        int    pulses;
        int    rise_j;
        int    fall_j;
        bit    held_seen;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[10];

    int n_vec = 0;
    int n_err = 0;

    int j, pulse_cyc, rises, first_rise, first_fall;
    bit held_seen, held_at_rise, prev_pulse, prev_held, lp;

    task automatic check(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic clear_obs();
        j = 0; pulse_cyc = 0; rises = 0; first_rise = 0; first_fall = 0;
        held_seen = 1'b0; held_at_rise = 1'b0; prev_pulse = 1'b0; prev_held = 1'b0;
    endtask

    task automatic drive(input logic level, input int n);
        key_n = level;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            j++;
            if (pulse) begin
                pulse_cyc++;
                lp = ~lp;
                if (!prev_pulse) begin
                    rises++;
                    if (first_rise == 0) begin
                        first_rise   = j;
                        held_at_rise = held;
                    end
                end
            end
            if (held) held_seen = 1'b1;
            if (prev_held && !held && first_fall == 0) first_fall = j;
            prev_pulse = pulse;
            prev_held  = held;
        end
    endtask

    task automatic score();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({e.name, "_pulse_cycles"}, pulse_cyc, e.pulses);
            check({e.name, "_pulse_rises"}, rises, e.pulses);
            check({e.name, "_rise_cycle"}, first_rise, e.rise_j);
            check({e.name, "_fall_cycle"}, first_fall, e.fall_j);
            check({e.name, "_held_seen"}, int'(held_seen), int'(e.held_seen));
            if (e.pulses > 0) check({e.name, "_held_at_rise"}, int'(held_at_rise), 1);
        end
    endtask

    task automatic push(input string nm, input int p, input int r, input int f, input bit hs);
        exp_t e;
        e.name = nm; e.pulses = p; e.rise_j = r; e.fall_j = f; e.held_seen = hs;
        exp_q.push_back(e);
    endtask

    initial begin
        int exp_lp;
        // low, high, pulses, rise j, fall j, held seen
        vecs[0] = '{2, 6, 0, 0, 0, 1'b0};
        vecs[1] = '{4, 6, 0, 0, 0, 1'b0};
        vecs[2] = '{5, 8, 1, 7, 12, 1'b1};
        vecs[3] = '{1, 6, 0, 0, 0, 1'b0};
        vecs[4] = '{20, 10, 1, 7, 27, 1'b1};
        vecs[5] = '{3, 6, 0, 0, 0, 1'b0};
        vecs[6] = '{8, 8, 1, 7, 15, 1'b1};
        vecs[7] = '{8, 8, 1, 7, 15, 1'b1};
        vecs[8] = '{8, 8, 1, 7, 15, 1'b1};
        vecs[9] = '{8, 8, 1, 7, 15, 1'b1};

        reset = 1'b0;
        key_n = 1'b1;
        lp    = 1'b0;
        #1;
        check("reset_pulse", int'(pulse), 0);
        check("reset_held", int'(held), 0);
        #43 reset = 1'b1;
        @(negedge clk);
        check("idle_pulse", int'(pulse), 0);
        check("idle_held", int'(held), 0);

        // Table-driven press/release vectors.
        lp = 1'b0;
        exp_lp = 0;
        for (int i = 0; i < 10; i++) begin
            push($sformatf("vec%0d", i), vecs[i].pulses, vecs[i].rise_j,
                 vecs[i].fall_j, vecs[i].held_seen);
            exp_lp = exp_lp ^ (vecs[i].pulses & 1);
            clear_obs();
            drive(1'b0, vecs[i].low_cyc);
            drive(1'b1, vecs[i].high_cyc);
            score();
        end
        check("limit_pressure_toggle", int'(lp), exp_lp);

        // Bounce high for 2 cycles during an accepted hold.
        push("bounce", 1, 7, 29, 1'b1);
        clear_obs();
        drive(1'b0, 10);
        drive(1'b1, 2);
        drive(1'b0, 10);
        drive(1'b1, 10);
        score();

        // Async reset mid PRESS_WAIT, then release with key still low.
        clear_obs();
        drive(1'b0, 4);
        #5 reset = 1'b0;
        #1;
        check("rst_pw_pulse", int'(pulse), 0);
        check("rst_pw_held", int'(held), 0);
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b1;
        push("after_reset", 1, 7, 17, 1'b1);
        clear_obs();
        drive(1'b0, 10);
        drive(1'b1, 10);
        score();

        // Async reset while pulse is high, release with key high.
        clear_obs();
        drive(1'b0, 7);
        check("pre_rst_pulse", int'(pulse), 1);
        #2 reset = 1'b0;
        #1;
        check("rst_pulse_cleared", int'(pulse), 0);
        check("rst_held_cleared", int'(held), 0);
        key_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        push("post_reset_idle", 0, 0, 0, 1'b0);
        clear_obs();
        drive(1'b1, 8);
        score();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
